mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port word memory between the core's instruction-fetch (I) and load/store (D) requesters.
//  Accepts one request at a time via valid/ready, sequences exactly one memory access, returns a held response.
//  Sits between the core front-end/LSU and the memory; sole driver of memory addr/data_in/mem_write.
// PARAMETERS
//  DATA_WIDTH  32  address and data width of requesters and memory
//  WORDS       64  memory depth in words; addresses >= WORDS flagged as error, no access issued
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, synchronous, active-low
//  i_req_valid  in   1   fetch request valid
//  i_req_ready  out  1   fetch request accepted this cycle
//  i_req_addr   in   DW  fetch address
//  i_rsp_valid  out  1   fetch response valid
//  i_rsp_ready  in   1   fetch response consumed
//  i_rsp_rdata  out  DW  fetched word
//  i_rsp_err    out  1   fetch address out of range
//  d_req_valid  in   1   load/store request valid
//  d_req_ready  out  1   load/store request accepted this cycle
//  d_req_we     in   1   1=store, 0=load
//  d_req_addr   in   DW  load/store address
//  d_req_wdata  in   DW  store data
//  d_rsp_valid  out  1   load/store response valid (stores also acked)
//  d_rsp_ready  in   1   load/store response consumed
//  d_rsp_rdata  out  DW  load data; 0 for stores
//  d_rsp_err    out  1   out-of-range, or store with addr[2:0]!=0
//  mem_addr     out  DW  memory address (registered)
//  mem_wdata    out  DW  memory write data (registered)
//  mem_write    out  1   memory write strobe, one cycle per store
//  mem_rdata    in   DW  memory combinational read data
// BEHAVIOUR
//  FSM IDLE -> ACCESS -> RESP -> IDLE; one outstanding transaction total.
//  IDLE: req_ready = grant & valid for the chosen requester only; other ready=0. Handshake cycle N latches
//   owner, we, addr, wdata, err into regs; err = (addr >= WORDS) | (we & addr[2:0]!=0).
//  ACCESS (N+1): mem_addr/mem_wdata driven from regs; mem_write = we & !err. rdata = err ? 0 : mem_rdata
//   captured at end of cycle (0 for stores). -> RESP.
//  RESP (N+2 onward): owner's rsp_valid=1, rdata/err held stable until rsp_ready; handshake -> IDLE.
//   Other requester's rsp_valid=0. Earliest next accept is the cycle after the response handshake.
//  Throughput: max one transaction per 3 cycles when rsp_ready held high.
//  Arbitration (IDLE only): single valid wins; both valid -> D wins (fixed priority).
//  req_ready never asserted outside IDLE; requesters hold valid/payload until ready.
//  Reset: state=IDLE; all *_ready, *_rsp_valid, mem_write = 0; rsp_rdata, rsp_err, mem_addr, mem_wdata = 0;
//   rr pointer = I. Reset in ACCESS/RESP abandons the transaction: no response, and mem_write is 0 in the reset cycle.
//  Out-of-range/misaligned: memory never written, response still returned with err=1.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: on simultaneous I/D valid, round-robin; 1-bit pointer flips to the non-winner
//   after every grant; first contended grant after reset goes to I.
//  Undefined: fixed priority D over I; I can starve under continuous D traffic (accepted).
// STRUCTURE
//  mem_arb_pkg: typedef enum {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t; typedef enum logic {OWN_I, OWN_D} arb_owner_t.
//  Sub-module mem_arb_pick: combinational grant from i_valid, d_valid, rr_ptr -> owner, grant_valid.
// TESTING
//  1 I load 0x04, mem[1]=0xDEADBEEF -> i_req_ready at N, i_rsp_valid at N+2, rdata=0xDEADBEEF, err=0.
//  2 D store 0x08 data 0x12345678 -> mem_write=1 exactly at N+1 with mem_addr=0x08; d_rsp_valid N+2, err=0, rdata=0.
//  3 D store 0x0C (addr[2:0]=4) -> mem_write stays 0, d_rsp_err=1; D store 0x40 (WORDS=64) -> err=1, no write.
//  4 I and D valid together, both held 4 transactions -> fixed: D,D,D,D; with MEM_ARB_RR_EN: I,D,I,D.
//  5 rsp_ready low 5 cycles in RESP -> rsp_valid/rdata stable, no new req_ready until handshake.
//  6 rst_n low during ACCESS of a store -> mem_write=0 that cycle, no response, IDLE next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types for the instruction-fetch / load-store memory port arbiter.
//   arb_state_t  : transaction sequencing states
//   arb_owner_t  : which requester owns the current transaction
//   other_owner(): the requester that did not win, used by the round-robin
//                  pointer when MEM_ARB_RR_EN is defined
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  // Stores must have addr[STORE_ALIGN_BITS-1:0] == 0.
  localparam int STORE_ALIGN_BITS = 3;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch (i_*), load/store (d_*) handshakes and the memory-side
//   signals of the memory port arbiter.
//   modport slave  : arbiter view (drives ready/response/memory outputs)
//   modport master : requester + memory view (drives requests, rsp_ready,
//                    mem_rdata)
//   Parameter DATA_WIDTH: address and data width.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [DATA_WIDTH-1:0] i_req_addr;
  logic                  i_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] i_rsp_rdata;
  logic                  i_rsp_err;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_we;
  logic [DATA_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_rsp_valid;
  logic                  d_rsp_ready;
  logic [DATA_WIDTH-1:0] d_rsp_rdata;
  logic                  d_rsp_err;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    input  mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output mem_addr, mem_wdata, mem_write
  );

  modport master (
    output i_req_valid, i_req_addr, i_rsp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    output mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick
//   Combinational grant selection between the fetch and load/store requesters.
//   Ports:
//     i_valid     in  fetch request pending
//     d_valid     in  load/store request pending
//     rr_ptr      in  owner to favour when both are pending
//     owner       out selected requester (OWN_I when nothing is pending)
//     grant_valid out at least one request pending
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  arb_owner_t rr_ptr,
  output arb_owner_t owner,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = i_valid | d_valid;
    if (i_valid && d_valid) begin
      owner = rr_ptr;
    end else if (d_valid) begin
      owner = OWN_D;
    end else begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-port word memory between instruction fetch (I) and
//   load/store (D). One transaction at a time: accept, one memory access,
//   then a response held until the owner consumes it.
//   Ports:
//     clk    in  clock
//     rst_n  in  synchronous active-low reset
//     bus    mem_port_arbiter_if.slave (requests, responses, memory port)
//   Parameters:
//     DATA_WIDTH  address/data width
//     WORDS       addresses >= WORDS are rejected with err=1, no access
//   Build option:
//     MEM_ARB_RR_EN  defined: round-robin on simultaneous requests
//                    undefined: D has fixed priority over I
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ARB_IDLE   | no transaction; ready offered to the picked requester
//   ARB_ACCESS | mem_addr/mem_wdata/mem_write presented, read data captured
//   ARB_RESP   | owner's rsp_valid high, waiting for its rsp_ready
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 64
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t            state;
  arb_owner_t            owner_q;
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_write_q;
  logic                  i_rsp_valid_q;
  logic                  d_rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  arb_owner_t            rr_ptr;
  arb_owner_t            owner_pick;
  logic                  grant_valid;

  mem_arb_pick u_pick (
    .i_valid     (bus.i_req_valid),
    .d_valid     (bus.d_req_valid),
    .rr_ptr      (rr_ptr),
    .owner       (owner_pick),
    .grant_valid (grant_valid)
  );

  logic                  accept;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_err;
  logic                  rsp_done;

  assign accept    = rst_n && (state == ARB_IDLE) && grant_valid;
  assign req_we    = (owner_pick == OWN_D) && bus.d_req_we;
  assign req_addr  = (owner_pick == OWN_D) ? bus.d_req_addr : bus.i_req_addr;
  assign req_wdata = (owner_pick == OWN_D) ? bus.d_req_wdata : '0;
  assign req_err   = (req_addr >= DATA_WIDTH'(WORDS)) ||
                     (req_we && (req_addr[STORE_ALIGN_BITS-1:0] != '0));
  assign rsp_done  = (state == ARB_RESP) &&
                     ((owner_q == OWN_I) ? bus.i_rsp_ready : bus.d_rsp_ready);

`ifdef MEM_ARB_RR_EN
  // Pointer moves to the loser after every grant, contended or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= OWN_I;
    end else if (accept) begin
      rr_ptr <= other_owner(owner_pick);
    end
  end
`else
  assign rr_ptr = OWN_D;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      owner_q       <= OWN_I;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_write_q   <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner_q     <= owner_pick;
            we_q        <= req_we;
            err_q       <= req_err;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
            mem_write_q <= req_we && !req_err;
            state       <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          mem_write_q   <= 1'b0;
          rsp_rdata_q   <= (err_q || we_q) ? '0 : bus.mem_rdata;
          rsp_err_q     <= err_q;
          i_rsp_valid_q <= (owner_q == OWN_I);
          d_rsp_valid_q <= (owner_q == OWN_D);
          state         <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_done) begin
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            state         <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps a store from landing in the cycle reset is
  // asserted, since the registered strobe only clears at the next edge.
  assign bus.i_req_ready = accept && (owner_pick == OWN_I);
  assign bus.d_req_ready = accept && (owner_pick == OWN_D);
  assign bus.mem_write   = mem_write_q && rst_n;
  assign bus.i_rsp_valid = i_rsp_valid_q && rst_n;
  assign bus.d_rsp_valid = d_rsp_valid_q && rst_n;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_rsp_rdata = rsp_rdata_q;
  assign bus.d_rsp_rdata = rsp_rdata_q;
  assign bus.i_rsp_err   = rsp_err_q;
  assign bus.d_rsp_err   = rsp_err_q;

endmodule
